// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU and load results in per-source FIFOs and issues at most
// one register-file write per cycle. LSU wins by default and the ALU wins once it has starved.
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_rdata,
    input  logic [2:0]      lsu_funct3,
    input  logic [1:0]      lsu_byte_off,
    output logic            rf_write_enable,
    output logic [4:0]      rf_write_addr,
    output logic [XLEN-1:0] rf_write_data,
    output logic            busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          r_alu_mem [FIFO_DEPTH];
    entry_t          r_lsu_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_alu_wptr, r_alu_rptr, r_lsu_wptr, r_lsu_rptr;
    logic [CW-1:0]   r_alu_cnt, r_lsu_cnt;
    logic [SW-1:0]   r_starve;
    logic            r_alu_ready, r_lsu_ready;
    logic            r_we;
    logic [4:0]      r_addr;
    logic [XLEN-1:0] r_data;

    logic            w_alu_push, w_lsu_push, w_alu_pop, w_lsu_pop;
    logic            w_alu_ne, w_lsu_ne;
    logic [CW-1:0]   w_alu_cnt_nxt, w_lsu_cnt_nxt;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_ext;
    entry_t          w_head;

    // Load extension happens at push so the FIFO stores final write data.
    always_comb begin
        w_byte     = lsu_rdata[{lsu_byte_off, 3'b000} +: 8];
        w_half     = lsu_byte_off[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
        w_load_ext = lsu_rdata;
        case (lsu_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_ext = lsu_rdata;
        endcase
    end

    always_comb begin
        w_alu_push    = alu_valid & r_alu_ready;
        w_lsu_push    = lsu_valid & r_lsu_ready;
        w_alu_ne      = (r_alu_cnt != '0);
        w_lsu_ne      = (r_lsu_cnt != '0);
        w_alu_pop     = w_alu_ne & (~w_lsu_ne | (r_starve == SW'(STARVE_LIMIT)));
        w_lsu_pop     = w_lsu_ne & ~w_alu_pop;
        w_alu_cnt_nxt = r_alu_cnt + CW'(w_alu_push) - CW'(w_alu_pop);
        w_lsu_cnt_nxt = r_lsu_cnt + CW'(w_lsu_push) - CW'(w_lsu_pop);
        w_head        = w_alu_pop ? r_alu_mem[r_alu_rptr] : r_lsu_mem[r_lsu_rptr];
    end

    // NOTE: FIFO storage has no reset; the cleared counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_alu_push) r_alu_mem[r_alu_wptr] <= '{rd: alu_rd, data: alu_data};
        if (w_lsu_push) r_lsu_mem[r_lsu_wptr] <= '{rd: lsu_rd, data: w_load_ext};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_wptr  <= '0;
            r_alu_rptr  <= '0;
            r_lsu_wptr  <= '0;
            r_lsu_rptr  <= '0;
            r_alu_cnt   <= '0;
            r_lsu_cnt   <= '0;
            r_starve    <= '0;
            r_alu_ready <= 1'b0;
            r_lsu_ready <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            if (w_alu_push) r_alu_wptr <= r_alu_wptr + PW'(1);
            if (w_lsu_push) r_lsu_wptr <= r_lsu_wptr + PW'(1);
            if (w_alu_pop)  r_alu_rptr <= r_alu_rptr + PW'(1);
            if (w_lsu_pop)  r_lsu_rptr <= r_lsu_rptr + PW'(1);
            r_alu_cnt   <= w_alu_cnt_nxt;
            r_lsu_cnt   <= w_lsu_cnt_nxt;
            r_alu_ready <= (w_alu_cnt_nxt != CW'(FIFO_DEPTH));
            r_lsu_ready <= (w_lsu_cnt_nxt != CW'(FIFO_DEPTH));

            // Starvation only accrues while an ALU entry is actually waiting.
            if (!w_alu_ne || w_alu_pop)
                r_starve <= '0;
            else if (w_lsu_pop && r_starve != SW'(STARVE_LIMIT))
                r_starve <= r_starve + SW'(1);

            if (w_alu_pop || w_lsu_pop) begin
                r_we   <= (w_head.rd != 5'd0);
                r_addr <= w_head.rd;
                r_data <= w_head.data;
            end else begin
                r_we   <= 1'b0;
            end
        end
    end

    assign alu_ready       = r_alu_ready;
    assign lsu_ready       = r_lsu_ready;
    assign rf_write_enable = r_we;
    assign rf_write_addr   = r_addr;
    assign rf_write_data   = r_data;
    assign busy            = w_alu_ne | w_lsu_ne | r_we;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, load extension, backpressure/starvation,
// rd=0 suppression, simultaneous sources and mid-operation reset.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_rdata;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_byte_off;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int we_count = 0;
    logic [4:0] wr_log [$];

    wb_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
        .lsu_funct3(lsu_funct3), .lsu_byte_off(lsu_byte_off),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_write_enable === 1'b1) begin
            we_count++;
            wr_log.push_back(rf_write_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
    logic [1:0]  ld_off [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FFA5, 32'h0000_00F0, 32'hFFFF_8070,
                                32'h0000_F0A5, 32'h8070_F0A5};

    initial begin
        int alu_sent, lsu_sent, alu_seen, first_alu, cnt_snap, cycles;
        logic alu_fire, lsu_fire;

        rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
        alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_rdata = '0;
        lsu_funct3 = '0; lsu_byte_off = '0;

        // Reset state
        tick(); tick();
        check("rst_we", rf_write_enable, 0);
        check("rst_addr", rf_write_addr, 0);
        check("rst_data", rf_write_data, 0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_lsu_ready", lsu_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("rel_alu_ready", alu_ready, 1);
        check("rel_lsu_ready", lsu_ready, 1);
        check("rel_busy", busy, 0);

        // Single ALU push: write visible only in the cycle after the pop edge
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
        tick();
        alu_valid = 1'b0;
        check("single_we_k", rf_write_enable, 0);
        check("single_busy_k", busy, 1);
        tick();
        check("single_we", rf_write_enable, 1);
        check("single_addr", rf_write_addr, 5);
        check("single_data", rf_write_data, 32'h0000_1234);
        tick();
        check("single_we_after", rf_write_enable, 0);
        check("single_hold_addr", rf_write_addr, 5);
        check("single_busy_after", busy, 0);

        // Load extension
        for (int i = 0; i < 5; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_rdata = 32'h8070_F0A5;
            lsu_funct3 = ld_f3[i]; lsu_byte_off = ld_off[i];
            tick();
            lsu_valid = 1'b0;
            tick();
            check($sformatf("ld%0d_we", i), rf_write_enable, 1);
            check($sformatf("ld%0d_data", i), rf_write_data, ld_exp[i]);
            tick();
        end

        // Backpressure and starvation
        wr_log.delete();
        alu_sent = 0; lsu_sent = 0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA000_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd16; lsu_rdata = 32'h5000_0000; lsu_funct3 = 3'b010;
        lsu_byte_off = 2'd0;
        cycles = 0;
        while (alu_sent < 6 && cycles < 60) begin
            alu_fire = alu_valid & alu_ready;
            lsu_fire = lsu_valid & lsu_ready;
            tick();
            cycles++;
            if (cycles == 2) check("bp_alu_ready_low", alu_ready, 0);
            if (alu_fire) begin
                alu_sent++;
                alu_rd = 5'(alu_sent + 1);
                alu_data = 32'hA000_0000 + 32'(alu_sent + 1);
            end
            if (lsu_fire) begin
                lsu_sent++;
                lsu_rd = 5'(16 + (lsu_sent % 15));
            end
        end
        check("bp_alu_sent", alu_sent, 6);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        cycles = 0;
        while (busy !== 1'b0 && cycles < 50) begin
            tick();
            cycles++;
        end
        check("bp_drain", busy, 0);
        first_alu = -1; alu_seen = 0;
        foreach (wr_log[i]) begin
            if (wr_log[i] < 5'd16) begin
                if (first_alu < 0) first_alu = i;
                alu_seen++;
                check($sformatf("bp_alu_order%0d", alu_seen), wr_log[i], alu_seen);
            end
        end
        check("bp_first_alu_pos", first_alu, 4);
        check("bp_alu_count", alu_seen, 6);

        // rd=0 entries are consumed but never written
        cnt_snap = we_count;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_rdata = 32'h0000_0001; lsu_funct3 = 3'b010;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        check("rd0_busy", busy, 1);
        tick(); tick(); tick();
        check("rd0_no_write", we_count, cnt_snap);
        check("rd0_busy_end", busy, 0);

        // Simultaneous push: LSU first, ALU next
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_0044;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_rdata = 32'h0000_0033; lsu_funct3 = 3'b010;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        check("sim_we1", rf_write_enable, 1);
        check("sim_addr1", rf_write_addr, 3);
        check("sim_data1", rf_write_data, 32'h0000_0033);
        tick();
        check("sim_we2", rf_write_enable, 1);
        check("sim_addr2", rf_write_addr, 4);
        check("sim_data2", rf_write_data, 32'h0000_0044);
        tick();
        check("sim_we3", rf_write_enable, 0);

        // Reset with entries pending
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h0000_0099;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_rdata = 32'h0000_00AA;
        tick(); tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        cnt_snap = we_count;
        check("mid_rst_we", rf_write_enable, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("mid_alu_ready", alu_ready, 1);
        check("mid_lsu_ready", lsu_ready, 1);
        tick(); tick(); tick();
        check("mid_no_stale", we_count, cnt_snap);
        check("mid_busy_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
